// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out LSB first, each bit held for CLOCK_FREQ/BAUD_RATE clock cycles.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);

   localparam int T  = CLOCK_FREQ / BAUD_RATE;
   localparam int CW = (T > 1) ? $clog2(T) : 1;

   localparam logic [CW-1:0] CYC_LAST = CW'(T - 1);
   localparam logic [CW-1:0] CYC_ONE  = CW'(1);
   localparam logic [3:0]    BIT_LAST = 4'd9;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   if (T < 2) begin : g_bad_baud
      $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end

   logic [0:0]    state;
   logic [CW-1:0] cyc_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift_reg;
   logic          handshake;

   // Ready is decoded from the state register only, so reset drives it high at once.
   assign data_in_ready = (state == IDLE);
   assign handshake     = data_in_valid && data_in_ready;

   // shift_reg holds {stop, data}; bit 0 is always the next bit to put on the line.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         serial_out <= 1'b1;
      end else if (state == IDLE) begin
         if (handshake) begin
            state      <= SEND;
            serial_out <= 1'b0;
            shift_reg  <= {1'b1, data_in};
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
         end
      end else begin
         if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
               state      <= IDLE;
               bit_cnt    <= '0;
               shift_reg  <= '0;
               serial_out <= 1'b1;
            end else begin
               bit_cnt    <= bit_cnt + 4'd1;
               serial_out <= shift_reg[0];
               shift_reg  <= {1'b0, shift_reg[8:1]};
            end
         end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at T=10: a frame-level model checked
// every cycle, plus literal expectations for frame contents and timing.
module tb_uart_transmitter;

   localparam int CLOCK_FREQ = 1000;
   localparam int BAUD_RATE  = 100;
   localparam int T          = CLOCK_FREQ / BAUD_RATE;
   localparam int FRAME      = 10 * T;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   uart_transmitter #(
      .CLOCK_FREQ(CLOCK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .serial_out   (serial_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: a busy line follows the 10-bit frame indexed by elapsed/T.
   bit         m_busy = 1'b0;
   int         m_elapsed = 0;
   logic [9:0] m_frame = 10'h3ff;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         m_elapsed++;
         if (m_elapsed == FRAME) m_busy = 1'b0;
      end else if (data_in_valid) begin
         m_busy    = 1'b1;
         m_elapsed = 0;
         m_frame   = {1'b1, data_in, 1'b0};
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_ready", data_in_ready, m_busy ? 0 : 1);
         check("model_line", serial_out, m_busy ? m_frame[m_elapsed / T] : 1'b1);
      end
   end

   // Leaves the bench at negedge+1 of the first cycle of the new frame.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk); #1;
      data_in       = b;
      data_in_valid = 1'b1;
      @(negedge clk); #1;
      data_in_valid = 1'b0;
   endtask

   // Samples mid-bit from frame cycle 0 until ready returns; optionally pulses valid.
   task automatic observe(output logic [9:0] bits, output int low,
                          input int inj_n, input logic [7:0] inj_d);
      int n;
      bits = '0;
      n    = 0;
      while (data_in_ready == 1'b0 && n < 300) begin
         if (n % T == T / 2) bits[n / T] = serial_out;
         if (n == inj_n) begin
            data_in       = inj_d;
            data_in_valid = 1'b1;
         end else if (n == inj_n + 1) begin
            data_in_valid = 1'b0;
         end
         n++;
         @(negedge clk); #1;
      end
      data_in_valid = 1'b0;
      low = n;
   endtask

   task automatic idle_run(input string name, input int cycles);
      int bad;
      bad = 0;
      repeat (cycles) begin
         @(negedge clk); #1;
         if (serial_out !== 1'b1 || data_in_ready !== 1'b1) bad++;
      end
      check(name, bad, 0);
   endtask

   initial begin
      logic [9:0] bits;
      int         low;
      int         n;
      int         highs;
      logic       prev;

      repeat (3) @(negedge clk);
      #1;
      check("rst_line", serial_out, 1);
      check("rst_ready", data_in_ready, 1);
      rst    = 1'b0;
      cmp_en = 1'b1;

      idle_run("idle_500", 500);

      send_byte(8'h55);
      observe(bits, low, -5, 8'h00);
      check("f55_bits", bits, 10'b1010101010);
      check("f55_ready_low", low, 100);
      check("f55_ready_back", data_in_ready, 1);

      send_byte(8'hA3);
      data_in = 8'hFF;
      observe(bits, low, -5, 8'h00);
      check("fa3_bits", bits, 10'b1101000110);
      check("fa3_ready_low", low, 100);

      send_byte(8'h34);
      observe(bits, low, 40, 8'h12);
      check("f34_bits", bits, 10'b1001101000);
      check("f34_ready_low", low, 100);
      idle_run("no_busy_byte", 150);

      @(negedge clk); #1;
      data_in       = 8'h00;
      data_in_valid = 1'b1;
      @(negedge clk); #1;
      data_in = 8'hFF;
      n       = 0;
      highs   = 0;
      prev    = serial_out;
      while (n < 300) begin
         @(negedge clk); #1;
         n++;
         if (data_in_ready) highs++;
         if (prev == 1'b1 && serial_out == 1'b0) break;
         prev = serial_out;
      end
      data_in_valid = 1'b0;
      check("b2b_start_spacing", n, 101);
      check("b2b_idle_gap", highs, 1);
      observe(bits, low, -5, 8'h00);
      check("fff_bits", bits, 10'b1111111110);
      check("fff_ready_low", low, 100);

      send_byte(8'h5A);
      repeat (35) @(negedge clk);
      #1;
      check("pre_rst_line", serial_out, 0);
      check("pre_rst_ready", data_in_ready, 0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_line", serial_out, 1);
      check("async_rst_ready", data_in_ready, 1);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      idle_run("post_rst_idle", 200);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
